i2c_reg_access_mstr: RTL and testbench



---
 rtl/i2c_reg_access_mstr_pkg.sv | 22 ++
 rtl/i2c_reg_access_mstr_byte_core.sv | 90 +++++++++
 rtl/i2c_reg_access_mstr.sv | 91 +++++++++
 tb/tb_i2c_reg_access_mstr.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_access_mstr_pkg.sv
// i2c_reg_access_mstr_pkg: shared encodings and helpers for the I2C register-access master
package i2c_reg_access_mstr_pkg;
  typedef enum logic [2:0] {
    M_WRITE = 3'b000,
    M_READ  = 3'b001,
    M_START = 3'b010,
    M_STOP  = 3'b100
  } mode_e;
  typedef enum logic [3:0] {
    S_IDLE, S_ST, S_WA, S_WS, S_WD, S_RS, S_WAR, S_RD, S_SP, S_FIN
  } seq_e;
  localparam logic C_WR = 1'b0;
  localparam logic C_RD = 1'b1;
  function automatic int f_div(input int f, input int b);
    return (f / (4 * b) < 1) ? 1 : f / (4 * b);
  endfunction
  function automatic logic [1:0] f_pad(input mode_e m, input logic [1:0] p, input logic d, input logic own);
    return m == M_START ? (p == 2'd0 ? {1'b1, ~own} : p == 2'd1 ? 2'b11 : {1'b0, ~p[0]}) :
           m == M_STOP  ? (p == 2'd0 ? 2'b00 : {p == 2'd3, 1'b1}) :
                          {d, p[1]};
  endfunction
endpackage

// File: rtl/i2c_reg_access_mstr_byte_core.sv
// i2c_byte_core: START/STOP/byte-level I2C engine with phase ticks and clock stretching
module i2c_byte_core
  import i2c_reg_access_mstr_pkg::*;
#(
  parameter int C_F_CK = 135_000_000,
  parameter int C_BPS  = 10_000_000
) (
  input  logic       CK_i,
  input  logic       RST_i,
  input  logic       REQ_i,
  input  mode_e      MODE_i,
  input  logic [7:0] TX_DAT_i,
  output logic       DONE_o,
  output logic [7:0] RX_DAT_o,
  output logic       RX_DAT_LT_o,
  output logic       ERR_o,
  output logic       SDAO_o,
  input  logic       SDAI_i,
  output logic       SCLO_o,
  input  logic       SCLI_i
);
  localparam int C_DIV = f_div(C_F_CK, C_BPS);
  localparam int CW = $clog2(C_DIV) + 1;
  logic act_q, own_q, sda_q, scl_q, done_q, lt_q, err_q;
  mode_e mode_q;
  logic [1:0] ph_q, pad_d;
  logic [3:0] bit_q, bit_d;
  logic [CW-1:0] cnt_q;
  logic [7:0] sh_q, sh_d, rx_q;
  logic stall, tick, fin;
  always_comb begin
    stall = act_q && !SCLI_i && (mode_q == M_START ? ph_q == 2'd1 : ph_q == 2'd2);
    tick = act_q && !stall && cnt_q == CW'(C_DIV - 1);
    fin = tick && ph_q == 2'd3 && (mode_q == M_START || mode_q == M_STOP || bit_q == 4'd8);
    bit_d = ph_q == 2'd3 ? bit_q + 4'd1 : bit_q;
    sh_d = (mode_q == M_WRITE && ph_q == 2'd3) ? {sh_q[6:0], 1'b0} :
           (mode_q == M_READ && ph_q == 2'd2 && bit_q < 4'd8) ? {sh_q[6:0], SDAI_i} : sh_q;
    pad_d = act_q ? f_pad(mode_q, ph_q + 2'd1, (mode_q == M_WRITE && bit_d < 4'd8) ? sh_d[7] : 1'b1, own_q)
                  : f_pad(MODE_i, 2'd0, MODE_i == M_WRITE ? TX_DAT_i[7] : 1'b1, own_q);
  end
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      act_q <= 1'b0;
      own_q <= 1'b0;
      sda_q <= 1'b1;
      scl_q <= 1'b1;
      done_q <= 1'b0;
      lt_q <= 1'b0;
      err_q <= 1'b0;
      mode_q <= M_START;
      ph_q <= '0;
      bit_q <= '0;
      cnt_q <= '0;
      sh_q <= '0;
      rx_q <= '0;
    end else begin
      done_q <= fin;
      lt_q <= fin && mode_q == M_READ;
      if (!act_q && REQ_i) begin
        act_q <= 1'b1;
        mode_q <= MODE_i;
        ph_q <= '0;
        bit_q <= '0;
        cnt_q <= '0;
        sh_q <= TX_DAT_i;
        err_q <= 1'b0;
        {sda_q, scl_q} <= pad_d;
      end else if (act_q) begin
        cnt_q <= stall ? cnt_q : tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          sh_q <= sh_d;
          bit_q <= bit_d;
          ph_q <= ph_q + 2'd1;
          if (mode_q == M_WRITE && ph_q == 2'd2 && bit_q == 4'd8 && SDAI_i) err_q <= 1'b1;
          if (fin) begin
            act_q <= 1'b0;
            own_q <= mode_q == M_START ? 1'b1 : mode_q == M_STOP ? 1'b0 : own_q;
            if (mode_q == M_READ) rx_q <= sh_q;
          end else {sda_q, scl_q} <= pad_d;
        end
      end
    end
  end
  assign DONE_o = done_q;
  assign RX_DAT_o = rx_q;
  assign RX_DAT_LT_o = lt_q;
  assign ERR_o = err_q;
  assign SDAO_o = sda_q;
  assign SCLO_o = scl_q;
endmodule

// File: rtl/i2c_reg_access_mstr.sv
// i2c_reg_access_mstr: sequencer running one I2C register write or read per request
module i2c_reg_access_mstr
  import i2c_reg_access_mstr_pkg::*;
#(
  parameter int C_F_CK = 135_000_000,
  parameter int C_BPS  = 10_000_000
) (
  input  logic       CK_i,
  input  logic       RST_i,
  input  logic       REQ_i,
  input  logic       RD_XWT_i,
  input  logic [6:0] SLV_ADRs_i,
  input  logic [7:0] SUB_ADRs_i,
  input  logic [7:0] TX_DATs_i,
  output logic [7:0] RX_DATs_o,
  output logic       DONE_o,
  output logic       BUSY_o,
  output logic       ERR_o,
  output logic       SDAO_o,
  input  logic       SDAI_i,
  output logic       SCLO_o,
  input  logic       SCLI_i
);
  seq_e st_q, st_n;
  mode_e cmode_q, md_n;
  logic rd_q, busy_q, done_q, err_q, creq_q;
  logic [6:0] slv_q;
  logic [7:0] sub_q, tx_q, rx_q, ctx_q, tx_n, crx;
  logic cdone, clt, cerr;
  i2c_byte_core #(.C_F_CK(C_F_CK), .C_BPS(C_BPS)) u_core (
    .CK_i(CK_i), .RST_i(RST_i), .REQ_i(creq_q), .MODE_i(cmode_q), .TX_DAT_i(ctx_q),
    .DONE_o(cdone), .RX_DAT_o(crx), .RX_DAT_LT_o(clt), .ERR_o(cerr),
    .SDAO_o(SDAO_o), .SDAI_i(SDAI_i), .SCLO_o(SCLO_o), .SCLI_i(SCLI_i)
  );
  always_comb begin
    st_n = cerr ? S_SP : st_q == S_ST ? S_WA : st_q == S_WA ? S_WS :
           st_q == S_WS ? (rd_q ? S_RS : S_WD) : st_q == S_RS ? S_WAR :
           st_q == S_WAR ? S_RD : st_q == S_SP ? S_FIN : S_SP;
    md_n = st_n == S_RS ? M_START : st_n == S_RD ? M_READ : st_n == S_SP ? M_STOP : M_WRITE;
    tx_n = st_n == S_WS ? sub_q : st_n == S_WD ? tx_q : {slv_q, st_n == S_WAR ? C_RD : C_WR};
  end
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      st_q <= S_IDLE;
      cmode_q <= M_START;
      rd_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      creq_q <= 1'b0;
      slv_q <= '0;
      sub_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      ctx_q <= '0;
    end else begin
      creq_q <= 1'b0;
      done_q <= 1'b0;
      if (clt) rx_q <= crx;
      case (st_q)
        S_IDLE: if (REQ_i) begin
          rd_q <= RD_XWT_i;
          slv_q <= SLV_ADRs_i;
          sub_q <= SUB_ADRs_i;
          tx_q <= TX_DATs_i;
          err_q <= 1'b0;
          busy_q <= 1'b1;
          creq_q <= 1'b1;
          cmode_q <= M_START;
          st_q <= S_ST;
        end
        S_FIN: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          st_q <= S_IDLE;
        end
        default: if (cdone) begin
          if (cerr) err_q <= 1'b1;
          st_q <= st_n;
          creq_q <= st_n != S_FIN;
          cmode_q <= md_n;
          ctx_q <= tx_n;
        end
      endcase
    end
  end
  assign RX_DATs_o = rx_q;
  assign DONE_o = done_q;
  assign BUSY_o = busy_q;
  assign ERR_o = err_q;
endmodule

// File: tb/tb_i2c_reg_access_mstr.sv
// tb_i2c_reg_access_mstr: directed checks of the I2C register master against an open-drain slave model
module tb_i2c_reg_access_mstr;
  logic CK_i = 1'b0, RST_i = 1'b1, REQ_i = 1'b0, RD_XWT_i = 1'b0;
  logic [6:0] SLV_ADRs_i = '0;
  logic [7:0] SUB_ADRs_i = '0, TX_DATs_i = '0;
  logic [7:0] RX_DATs_o;
  logic DONE_o, BUSY_o, ERR_o, SDAO_o, SCLO_o;
  logic slv_sda = 1'b1, slv_scl = 1'b1, present = 1'b1, stretch_en = 1'b0;
  logic [7:0] rd_val = 8'h55;
  logic sda, scl;
  assign sda = SDAO_o & slv_sda;
  assign scl = SCLO_o & slv_scl;
  i2c_reg_access_mstr #(.C_F_CK(1000), .C_BPS(100)) dut (
    .CK_i(CK_i), .RST_i(RST_i), .REQ_i(REQ_i), .RD_XWT_i(RD_XWT_i),
    .SLV_ADRs_i(SLV_ADRs_i), .SUB_ADRs_i(SUB_ADRs_i), .TX_DATs_i(TX_DATs_i),
    .RX_DATs_o(RX_DATs_o), .DONE_o(DONE_o), .BUSY_o(BUSY_o), .ERR_o(ERR_o),
    .SDAO_o(SDAO_o), .SDAI_i(sda), .SCLO_o(SCLO_o), .SCLI_i(scl)
  );
  always #5 CK_i = ~CK_i;
  int checks = 0, errors = 0;
  int bc = 0, bi = 0, nb = 0, starts = 0, stops = 0, hold = 0, done_cnt = 0, stall_cnt = 0;
  logic [7:0] sr = '0;
  logic [7:0] logb [0:63];
  logic rd_dir = 1'b0, reading = 1'b0, mack = 1'b0, ps = 1'b1, pc = 1'b1, s, c;
  initial begin
    forever begin
      @(negedge CK_i);
      s = sda;
      c = scl;
      if (DONE_o) done_cnt++;
      if (SCLO_o && !c) stall_cnt++;
      if (hold > 0) begin
        hold--;
        if (hold == 0) slv_scl = 1'b1;
      end
      if (pc && c && ps && !s) begin
        starts++;
        bc = 0;
        bi = 0;
        reading = 1'b0;
        slv_sda = 1'b1;
      end else if (pc && c && !ps && s) stops++;
      else if (!pc && c) begin
        if (bc < 8) sr = {sr[6:0], s};
        else if (bc == 8) mack = s;
        bc++;
      end else if (pc && !c) begin
        if (bc == 8) begin
          if (nb < 64) logb[nb] = sr;
          nb++;
          if (!reading && bi == 0) rd_dir = sr[0];
          slv_sda = reading || !present;
        end else if (bc == 9) begin
          reading = !reading && rd_dir && bi == 0 && present;
          bc = 0;
          bi++;
          slv_sda = reading ? rd_val[7] : 1'b1;
        end else if (reading && bc >= 1 && bc < 8) slv_sda = rd_val[7 - bc];
        if (stretch_en && bi == 1 && bc == 3 && !reading) begin
          slv_scl = 1'b0;
          hold = 20;
        end
      end
      pc = c;
      ps = s;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge CK_i);
  endtask
  task automatic req(input logic rd, input logic [6:0] sa, input logic [7:0] ra, input logic [7:0] d);
    @(negedge CK_i);
    RD_XWT_i = rd;
    SLV_ADRs_i = sa;
    SUB_ADRs_i = ra;
    TX_DATs_i = d;
    REQ_i = 1'b1;
    @(negedge CK_i);
    REQ_i = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && !DONE_o; i++) @(negedge CK_i);
    chk({tag, "_done"}, 32'(DONE_o), 1);
  endtask
  int b, s0, p0, d0, t0;
  initial begin
    cyc(3);
    chk("rst_sdao", 32'(SDAO_o), 1);
    chk("rst_sclo", 32'(SCLO_o), 1);
    chk("rst_done", 32'(DONE_o), 0);
    chk("rst_busy", 32'(BUSY_o), 0);
    chk("rst_err", 32'(ERR_o), 0);
    chk("rst_rx", 32'(RX_DATs_o), 0);
    RST_i = 1'b0;
    cyc(2);
    b = nb; s0 = starts; p0 = stops; d0 = done_cnt;
    req(1'b0, 7'h3E, 8'h76, 8'h7E);
    chk("wr_busy", 32'(BUSY_o), 1);
    wait_done("wr");
    chk("wr_err", 32'(ERR_o), 0);
    chk("wr_busy_at_done", 32'(BUSY_o), 0);
    cyc(10);
    chk("wr_done_cnt", 32'(done_cnt - d0), 1);
    chk("wr_nbytes", 32'(nb - b), 3);
    chk("wr_b0", 32'(logb[b]), 32'h7C);
    chk("wr_b1", 32'(logb[b + 1]), 32'h76);
    chk("wr_b2", 32'(logb[b + 2]), 32'h7E);
    chk("wr_starts", 32'(starts - s0), 1);
    chk("wr_stops", 32'(stops - p0), 1);
    chk("wr_busy_after", 32'(BUSY_o), 0);
    b = nb; s0 = starts; p0 = stops;
    req(1'b1, 7'h3E, 8'h76, 8'h00);
    wait_done("rd");
    chk("rd_rx", 32'(RX_DATs_o), 32'h55);
    chk("rd_err", 32'(ERR_o), 0);
    cyc(10);
    chk("rd_nbytes", 32'(nb - b), 4);
    chk("rd_b0", 32'(logb[b]), 32'h7C);
    chk("rd_b1", 32'(logb[b + 1]), 32'h76);
    chk("rd_b2", 32'(logb[b + 2]), 32'h7D);
    chk("rd_b3", 32'(logb[b + 3]), 32'h55);
    chk("rd_starts", 32'(starts - s0), 2);
    chk("rd_stops", 32'(stops - p0), 1);
    chk("rd_master_nack", 32'(mack), 1);
    present = 1'b0;
    b = nb; p0 = stops; d0 = done_cnt;
    req(1'b0, 7'h3E, 8'h76, 8'h7E);
    wait_done("nack");
    chk("nack_err", 32'(ERR_o), 1);
    chk("nack_rx", 32'(RX_DATs_o), 32'h55);
    cyc(10);
    chk("nack_nbytes", 32'(nb - b), 1);
    chk("nack_b0", 32'(logb[b]), 32'h7C);
    chk("nack_stops", 32'(stops - p0), 1);
    chk("nack_done_cnt", 32'(done_cnt - d0), 1);
    chk("nack_err_sticky", 32'(ERR_o), 1);
    present = 1'b1;
    stretch_en = 1'b1;
    b = nb; t0 = stall_cnt;
    req(1'b0, 7'h3E, 8'h76, 8'h7E);
    wait_done("str");
    chk("str_err", 32'(ERR_o), 0);
    cyc(10);
    stretch_en = 1'b0;
    chk("str_nbytes", 32'(nb - b), 3);
    chk("str_sub", 32'(logb[b + 1]), 32'h76);
    chk("str_stall_window", 32'((stall_cnt - t0) >= 15 && (stall_cnt - t0) <= 19), 1);
    b = nb; s0 = starts; d0 = done_cnt;
    req(1'b0, 7'h3E, 8'h76, 8'h7E);
    cyc(40);
    chk("rep_busy", 32'(BUSY_o), 1);
    req(1'b1, 7'h11, 8'h22, 8'h33);
    wait_done("rep");
    cyc(500);
    chk("rep_done_cnt", 32'(done_cnt - d0), 1);
    chk("rep_nbytes", 32'(nb - b), 3);
    chk("rep_b0", 32'(logb[b]), 32'h7C);
    chk("rep_b2", 32'(logb[b + 2]), 32'h7E);
    chk("rep_starts", 32'(starts - s0), 1);
    chk("rep_busy_after", 32'(BUSY_o), 0);
    req(1'b0, 7'h3E, 8'h76, 8'h7E);
    cyc(110);
    chk("mid_busy", 32'(BUSY_o), 1);
    RST_i = 1'b1;
    @(negedge CK_i);
    chk("mid_sdao", 32'(SDAO_o), 1);
    chk("mid_sclo", 32'(SCLO_o), 1);
    chk("mid_busy_rst", 32'(BUSY_o), 0);
    RST_i = 1'b0;
    cyc(5);
    b = nb;
    req(1'b0, 7'h3E, 8'h76, 8'h7E);
    wait_done("post");
    chk("post_err", 32'(ERR_o), 0);
    cyc(10);
    chk("post_nbytes", 32'(nb - b), 3);
    chk("post_b0", 32'(logb[b]), 32'h7C);
    chk("post_b1", 32'(logb[b + 1]), 32'h76);
    chk("post_b2", 32'(logb[b + 2]), 32'h7E);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
